// File: rtl/path_walker_pkg.sv
// -----------------------------------------------------------------------------
// path_walker_pkg
//   Shared constants for the hypercube path walker: hop entry width, slot
//   counts per group, FSM state encodings, the registered length bundle and
//   a helper that finds the next nonempty group.
// -----------------------------------------------------------------------------
package path_walker_pkg;

    localparam int DIM_W   = 2;
    localparam int N0      = 4;
    localparam int N1      = 3;
    localparam int N2      = 2;
    localparam int NUM_GRP = 3;

    localparam int D0_W = N0 * DIM_W;
    localparam int D1_W = N1 * DIM_W;
    localparam int D2_W = N2 * DIM_W;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WALK = 1'b1;

    // Group index value meaning "no further nonempty group"
    localparam logic [1:0] GRP_NONE = 2'd3;

    // Clamped lengths of the three groups
    typedef struct packed {
        logic [2:0] l0;
        logic [1:0] l1;
        logic [1:0] l2;
    } path_len_t;

    // Next nonempty group strictly after g, or GRP_NONE.
    function automatic logic [1:0] next_grp(input logic [1:0] g,
                                            input logic [1:0] l1,
                                            input logic [1:0] l2);
        logic [1:0] n;
        n = GRP_NONE;
        if (g == 2'd0) begin
            if (l1 != 2'd0)      n = 2'd1;
            else if (l2 != 2'd0) n = 2'd2;
        end else if (g == 2'd1) begin
            if (l2 != 2'd0)      n = 2'd2;
        end
        return n;
    endfunction

endpackage

// File: rtl/path_walker_len_check.sv
// -----------------------------------------------------------------------------
// path_len_check
//   Combinational legalisation of a path descriptor's lengths.
//   Ports:
//     len_0_i, len_1_i, len_2_i : raw per-group lengths
//     group_i                   : number of active groups (1..3)
//     l0_o, l1_o, l2_o          : effective (clamped / masked) lengths
//     err_o                     : descriptor is illegal in some way
//     no_walk_o                 : descriptor yields no hops at all
// -----------------------------------------------------------------------------
module path_len_check
    import path_walker_pkg::*;
(
    input  logic [2:0] len_0_i,
    input  logic [1:0] len_1_i,
    input  logic [1:0] len_2_i,
    input  logic [1:0] group_i,
    output logic [2:0] l0_o,
    output logic [1:0] l1_o,
    output logic [1:0] l2_o,
    output logic       err_o,
    output logic       no_walk_o
);

    logic grp_zero;
    logic len0_over;
    logic len2_over;
    logic empty;

    assign grp_zero  = (group_i == 2'd0);
    assign len0_over = (len_0_i > 3'(N0));
    assign len2_over = (group_i == 2'd3) && (len_2_i == 2'd3);

    assign l0_o = len0_over ? 3'(N0) : len_0_i;
    assign l1_o = (group_i >= 2'd2) ? len_1_i : 2'd0;
    assign l2_o = (group_i == 2'd3) ? (len2_over ? 2'(N2) : len_2_i) : 2'd0;

    assign empty = (l0_o == 3'd0) && (l1_o == 2'd0) && (l2_o == 2'd0);

    // A zero group count suppresses the walk even if len_0_i is nonzero.
    assign no_walk_o = grp_zero || empty;
    assign err_o     = grp_zero || len0_over || len2_over || empty;

endmodule

// File: rtl/path_walker.sv
// -----------------------------------------------------------------------------
// path_walker
//   Accepts one packed hypercube path descriptor per valid/ready handshake
//   and replays it as a serial hop stream, one dimension per cycle: group 0
//   entries, then group 1, then group 2, LSB entry of each group first.
//   Ports:
//     clk, rst                    : clock, asynchronous active-high reset
//     path_valid_i / path_ready_o : descriptor handshake (ready = idle)
//     data_0_i/1_i/2_i            : packed group entries, entry k at [2k+1:2k]
//     len_0_i/1_i/2_i, group_i    : per-group lengths, active group count
//     hop_valid_o / hop_ready_i   : hop stream handshake
//     hop_dim_o, hop_grp_o        : current hop dimension and group index
//     hop_last_o                  : current hop is the final one of the path
//     done_o                      : one-cycle pulse after the final hop
//     err_o                       : one-cycle pulse for an illegal descriptor
// -----------------------------------------------------------------------------
module path_walker
    import path_walker_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             path_valid_i,
    output logic             path_ready_o,
    input  logic [D0_W-1:0]  data_0_i,
    input  logic [D1_W-1:0]  data_1_i,
    input  logic [D2_W-1:0]  data_2_i,
    input  logic [2:0]       len_0_i,
    input  logic [1:0]       len_1_i,
    input  logic [1:0]       len_2_i,
    input  logic [1:0]       group_i,
    output logic             hop_valid_o,
    input  logic             hop_ready_i,
    output logic [DIM_W-1:0] hop_dim_o,
    output logic [1:0]       hop_grp_o,
    output logic             hop_last_o,
    output logic             done_o,
    output logic             err_o
);

    // Length legalisation of the incoming descriptor
    logic [2:0] chk_l0;
    logic [1:0] chk_l1;
    logic [1:0] chk_l2;
    logic       chk_err;
    logic       chk_no_walk;

    path_len_check u_len_check (
        .len_0_i   (len_0_i),
        .len_1_i   (len_1_i),
        .len_2_i   (len_2_i),
        .group_i   (group_i),
        .l0_o      (chk_l0),
        .l1_o      (chk_l1),
        .l2_o      (chk_l2),
        .err_o     (chk_err),
        .no_walk_o (chk_no_walk)
    );

    // State
    logic [0:0]      state_q, state_d;
    logic [1:0]      grp_q,   grp_d;
    logic [1:0]      idx_q,   idx_d;
    path_len_t       len_q,   len_d;
    logic [D0_W-1:0] data_0_q, data_0_d;
    logic [D1_W-1:0] data_1_q, data_1_d;
    logic [D2_W-1:0] data_2_q, data_2_d;
    logic            done_q,  done_d;
    logic            err_q,   err_d;

    // Hop selection from the registered descriptor
    logic             walking;
    logic [2:0]       cur_len;
    logic             last_in_grp;
    logic [1:0]       nxt_grp;
    logic [DIM_W-1:0] cur_dim;
    logic [2:0]       base_01;
    logic [1:0]       base_2;

    assign walking = (state_q == ST_WALK);

    // Bit offset of the current entry; group 2 only holds two entries so
    // its offset needs one bit less.
    assign base_01 = {idx_q, 1'b0};
    assign base_2  = {idx_q[0], 1'b0};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cur_len = len_q.l0;
        cur_dim = data_0_q[base_01 +: DIM_W];
        if (grp_q == 2'd1) begin
            cur_len = {1'b0, len_q.l1};
            cur_dim = data_1_q[base_01 +: DIM_W];
        end else if (grp_q == 2'd2) begin
            cur_len = {1'b0, len_q.l2};
            cur_dim = data_2_q[base_2 +: DIM_W];
        end
    end

    assign last_in_grp = (({1'b0, idx_q} + 3'd1) == cur_len);
    assign nxt_grp     = next_grp(grp_q, len_q.l1, len_q.l2);

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        idx_d    = idx_q;
        len_d    = len_q;
        data_0_d = data_0_q;
        data_1_d = data_1_q;
        data_2_d = data_2_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (state_q == ST_IDLE) begin
            if (path_valid_i) begin
                err_d    = chk_err;
                len_d    = '{l0: chk_l0, l1: chk_l1, l2: chk_l2};
                data_0_d = data_0_i;
                data_1_d = data_1_i;
                data_2_d = data_2_i;
                if (!chk_no_walk) begin
                    state_d = ST_WALK;
                    idx_d   = 2'd0;
                    // Start at the first nonempty group so empty groups
                    // cost no bubble cycle.
                    grp_d   = (chk_l0 != 3'd0) ? 2'd0
                                               : next_grp(2'd0, chk_l1, chk_l2);
                end
            end
        end else if (hop_ready_i) begin
            if (!last_in_grp) begin
                idx_d = idx_q + 2'd1;
            end else if (nxt_grp == GRP_NONE) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                grp_d = nxt_grp;
                idx_d = 2'd0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grp_q    <= 2'd0;
            idx_q    <= 2'd0;
            len_q    <= '0;
            data_0_q <= '0;
            data_1_q <= '0;
            data_2_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grp_q    <= grp_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            data_0_q <= data_0_d;
            data_1_q <= data_1_d;
            data_2_q <= data_2_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Outputs; hop fields are forced to zero while idle.
    assign path_ready_o = !walking;
    assign hop_valid_o  = walking;
    assign hop_dim_o    = walking ? cur_dim : '0;
    assign hop_grp_o    = walking ? grp_q : 2'd0;
    assign hop_last_o   = walking && last_in_grp && (nxt_grp == GRP_NONE);
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
